// File: rtl/display_scan_ctrl_pkg.sv
// Shared definitions for the display scan controller: segment codes
// (active-low {g,f,e,d,c,b,a}), scan state encoding and digit count.
package disp_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic {
    GAP   = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  // Active-low anode pattern selecting a single digit.
  function automatic logic [NUM_DIGITS-1:0] anode_mask(input logic [1:0] idx);
    return ~(NUM_DIGITS'(1) << idx);
  endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Digit/display bus of the scan controller. The slave modport is the
// controller side; the master modport is the side supplying digits.
// With SCAN_DIM_EN defined a 2-bit brightness input is added.
interface display_scan_ctrl_if;

  logic [3:0] units;
  logic [3:0] dec;
  logic [3:0] hungr;
  logic [3:0] thous;
  logic       load;
  logic       lz_blank;
`ifdef SCAN_DIM_EN
  logic [1:0] bright;
`endif
  logic [3:0] an;
  logic [6:0] seg;
  logic       frame_done;

  modport slave (
    input  units, dec, hungr, thous, load, lz_blank,
`ifdef SCAN_DIM_EN
    input  bright,
`endif
    output an, seg, frame_done
  );

  modport master (
    output units, dec, hungr, thous, load, lz_blank,
`ifdef SCAN_DIM_EN
    output bright,
`endif
    input  an, seg, frame_done
  );

endinterface

// File: rtl/display_scan_ctrl_bcd_to_seg.sv
// Combinational BCD to active-low 7-segment decode with a blank override.
// Non-decimal codes 10..15 render as a dash.
module bcd_to_seg
  import disp_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  // Decode digit, blank wins over any value
  always_comb begin
    seg = SEG_DASH;
    if (blank) begin
      seg = SEG_BLANK;
    end else begin
      case (bcd)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with blanking gaps,
// frame-synchronous double buffering and optional leading-zero blanking.
// Optional feature macro: SCAN_DIM_EN (per-frame brightness via anode PWM).
module display_scan_ctrl
  import disp_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 50000,
  parameter int unsigned GAP_CYCLES = 8
) (
  input  logic              clk,
  input  logic              rst,
  display_scan_ctrl_if.slave bus
);

  localparam int unsigned CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

  scan_state_t      state, state_nxt;
  logic [1:0]       idx, idx_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             gap_done, drive_done;
  logic             boundary, frame_end;

  logic [NUM_DIGITS-1:0][3:0] live, pending, active;
  logic                       pending_valid;
  logic [NUM_DIGITS-1:0]      lz_mask;
  logic [6:0]                 seg_dec;
  logic                       lit;

  assign live = {bus.thous, bus.hungr, bus.dec, bus.units};

  // Scan state register: state, digit index and phase counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= GAP;
      idx   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic: GAP -> DRIVE keeps idx, DRIVE -> GAP advances it
  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    cnt_nxt    = cnt + 1'b1;
    gap_done   = 1'b0;
    drive_done = 1'b0;
    case (state)
      GAP: begin
        if (cnt == GAP_LAST) begin
          state_nxt = DRIVE;
          cnt_nxt   = '0;
          gap_done  = 1'b1;
        end
      end
      DRIVE: begin
        if (cnt == DRIVE_LAST) begin
          state_nxt  = GAP;
          idx_nxt    = idx + 2'd1;
          cnt_nxt    = '0;
          drive_done = 1'b1;
        end
      end
      default: begin
        state_nxt = GAP;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign boundary  = gap_done && (idx == 2'd0);
  assign frame_end = drive_done && (idx == 2'd3);

  // Double buffer: a load coinciding with the frame boundary bypasses the
  // pending stage so the newest value is what the new frame shows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending       <= '0;
      active        <= '0;
      pending_valid <= 1'b0;
    end else if (boundary) begin
      if (bus.load) begin
        active <= live;
      end else if (pending_valid) begin
        active <= pending;
      end
      pending_valid <= 1'b0;
    end else if (bus.load) begin
      pending       <= live;
      pending_valid <= 1'b1;
    end
  end

  // Leading-zero blanking on the active frame; digit 0 always shows
  always_comb begin
    lz_mask    = '0;
    lz_mask[3] = bus.lz_blank && (active[3] == 4'd0);
    lz_mask[2] = lz_mask[3] && (active[2] == 4'd0);
    lz_mask[1] = lz_mask[2] && (active[1] == 4'd0);
  end

  bcd_to_seg u_dec (
    .bcd   (active[idx]),
    .blank (lz_mask[idx]),
    .seg   (seg_dec)
  );

`ifdef SCAN_DIM_EN
  logic [1:0]  bright_q;
  logic [31:0] on_limit;

  // Brightness only changes at the frame boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bright_q <= 2'd3;
    end else if (boundary) begin
      bright_q <= bus.bright;
    end
  end

  // Anode on-window within the DRIVE slot
  always_comb begin
    on_limit = ((32'(bright_q) + 32'd1) * 32'(CLK_DIV)) / 32'd4;
    lit      = (32'(cnt) < on_limit);
  end
`else
  assign lit = 1'b1;
`endif

  // Registered display outputs, one cycle behind the scan state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.an         <= '1;
      bus.seg        <= '1;
      bus.frame_done <= 1'b0;
    end else begin
      bus.frame_done <= frame_end;
      if (state == DRIVE && lit) begin
        bus.an  <= anode_mask(idx);
        bus.seg <= seg_dec;
      end else begin
        bus.an  <= '1;
        bus.seg <= '1;
      end
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl: directed scenarios plus random
// loads, compared every cycle against a frame-position based reference model.
module tb_display_scan_ctrl;

  localparam int CD = 4;
  localparam int GC = 1;
  localparam int SLOT = CD + GC;
  localparam int P = 4 * SLOT;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  display_scan_ctrl_if bus ();

  display_scan_ctrl #(.CLK_DIV(CD), .GAP_CYCLES(GC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

  int         k;
  logic [3:0] act  [4];
  logic [3:0] pend [4];
  bit         pv;
  int         vectors = 0;
  int         miscompares = 0;
  logic [3:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_fd;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, got, exp, k);
    end
  endtask

  task automatic model_clear();
    k  = 0;
    pv = 0;
    for (int i = 0; i < 4; i++) begin
      act[i]  = 4'd0;
      pend[i] = 4'd0;
    end
  endtask

  // Expected outputs for the scan position of cycle k
  task automatic predict();
    int  q, s, w;
    bit  blank;
    q = k % P;
    s = q / SLOT;
    w = q % SLOT;
    exp_fd = (q == P - 1);
    if (w < GC) begin
      exp_an  = 4'hF;
      exp_seg = 7'h7F;
    end else begin
      exp_an = 4'hF ^ (4'h1 << s);
      blank  = bus.lz_blank && (s > 0);
      for (int j = s; j < 4; j++) if (act[j] != 4'd0) blank = 0;
      exp_seg = blank ? 7'h7F : seg_tab[act[s]];
    end
  endtask

  task automatic step();
    logic [3:0] in_d [4];
    int kn;
    @(posedge clk);
    predict();
    in_d[0] = bus.units; in_d[1] = bus.dec; in_d[2] = bus.hungr; in_d[3] = bus.thous;
    kn = k + 1;
    if (kn % P == GC) begin
      if (bus.load) begin
        for (int i = 0; i < 4; i++) act[i] = in_d[i];
      end else if (pv) begin
        for (int i = 0; i < 4; i++) act[i] = pend[i];
      end
      pv = 0;
    end else if (bus.load) begin
      for (int i = 0; i < 4; i++) pend[i] = in_d[i];
      pv = 1;
    end
    k = kn;
    @(negedge clk);
    check("an", {4'h0, bus.an}, {4'h0, exp_an});
    check("seg", {1'b0, bus.seg}, {1'b0, exp_seg});
    check("frame_done", {7'h0, bus.frame_done}, {7'h0, exp_fd});
  endtask

  task automatic load_val(input logic [3:0] t, input logic [3:0] h,
                          input logic [3:0] d, input logic [3:0] u);
    bus.thous = t; bus.hungr = h; bus.dec = d; bus.units = u;
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic goto_pos(input int target);
    for (int i = 0; i < P && (k % P) != target; i++) step();
  endtask

  initial begin
    bit found;
    bus.load = 1'b0; bus.lz_blank = 1'b0;
    bus.units = 4'd0; bus.dec = 4'd0; bus.hungr = 4'd0; bus.thous = 4'd0;
`ifdef SCAN_DIM_EN
    bus.bright = 2'd3;
`endif
    model_clear();
    rst = 1'b1;
    #1;
    check("rst_an", {4'h0, bus.an}, 8'h0F);
    check("rst_seg", {1'b0, bus.seg}, 8'h7F);
    check("rst_frame_done", {7'h0, bus.frame_done}, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_clear();

    // Scan order and timing with digits 1,2,3,4 loaded at the first boundary
    load_val(4'd1, 4'd2, 4'd3, 4'd4);
    run(2 * P);

    // Decode including a non-decimal dash
    load_val(4'd8, 4'd0, 4'hA, 4'd9);
    run(2 * P);

    // Leading-zero blanking
    bus.lz_blank = 1'b1;
    load_val(4'd0, 4'd0, 4'd5, 4'd0);
    run(2 * P);
    load_val(4'd0, 4'd0, 4'd0, 4'd0);
    run(2 * P);
    bus.lz_blank = 1'b0;

    // Tear-free update: two loads mid-frame, last one wins next frame
    goto_pos(7);
    load_val(4'd1, 4'd2, 4'd3, 4'd4);
    step();
    load_val(4'd5, 4'd6, 4'd7, 4'd8);
    run(2 * P);

    // Load exactly on the frame boundary, with a stale pending value queued
    goto_pos(3);
    load_val(4'd2, 4'd2, 4'd2, 4'd2);
    goto_pos(GC - 1 + P);
    goto_pos(GC - 1);
    load_val(4'd9, 4'd8, 4'd7, 4'd6);
    run(P);

    // Randomized loads and blanking mode
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) bus.lz_blank = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) begin
        load_val(4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      end else begin
        step();
      end
    end

    // Asynchronous reset while digit 2 is being driven
    bus.lz_blank = 1'b0;
    load_val(4'd4, 4'd3, 4'd2, 4'd1);
    found = 0;
    for (int i = 0; i < 2 * P && !found; i++) begin
      step();
      if (exp_an == 4'hB) found = 1;
    end
    vectors++;
    assert (found) else begin
      miscompares++;
      $error("FAIL reach_digit2: observed %0d expected %0d", found, 1);
    end
    #2 rst = 1'b1;
    #1;
    check("async_rst_an", {4'h0, bus.an}, 8'h0F);
    check("async_rst_seg", {1'b0, bus.seg}, 8'h7F);
    check("async_rst_frame_done", {7'h0, bus.frame_done}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    run(2 * P);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
